// File: rtl/cond_flag_stage.sv
// Condition/flag stage between the ALU and writeback: owns the NZCV register,
// evaluates each op's ARM condition field and holds one op in a valid/ready buffer.
module cond_flag_stage #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        cond,
    input  logic [3:0]        alu_flags,
    input  logic [1:0]        flag_w,
    input  logic [DATA_W-1:0] alu_result,
    input  logic [ADDR_W-1:0] wa3,
    input  logic              reg_w,
    input  logic              mem_w,
    input  logic              pcs,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_result,
    output logic [ADDR_W-1:0] out_wa3,
    output logic              out_reg_w,
    output logic              out_mem_w,
    output logic              out_pcsrc,
    output logic [3:0]        flags,
    output logic [CNT_W-1:0]  fail_count
);
    typedef struct packed {
        logic [DATA_W-1:0] result;
        logic [ADDR_W-1:0] wa3;
        logic              reg_w;
        logic              mem_w;
        logic              pcsrc;
    } wb_op_t;

    wb_op_t            r_op;
    wb_op_t            w_op_next;
    logic              r_out_valid;
    logic [3:0]        r_flags;
    logic [CNT_W-1:0]  r_fail_count;
    logic              w_cond_ex;
    logic              w_accept;
    logic              w_drain;
    logic              w_n, w_z, w_c, w_v;

    // Condition is judged against the committed flags, not this op's ALU flags.
    assign {w_n, w_z, w_c, w_v} = r_flags;

    always_comb begin
        w_cond_ex = 1'b1;
        case (cond)
            4'h0:    w_cond_ex = w_z;
            4'h1:    w_cond_ex = ~w_z;
            4'h2:    w_cond_ex = w_c;
            4'h3:    w_cond_ex = ~w_c;
            4'h4:    w_cond_ex = w_n;
            4'h5:    w_cond_ex = ~w_n;
            4'h6:    w_cond_ex = w_v;
            4'h7:    w_cond_ex = ~w_v;
            4'h8:    w_cond_ex = w_c & ~w_z;
            4'h9:    w_cond_ex = ~w_c | w_z;
            4'hA:    w_cond_ex = (w_n == w_v);
            4'hB:    w_cond_ex = (w_n != w_v);
            4'hC:    w_cond_ex = ~w_z & (w_n == w_v);
            4'hD:    w_cond_ex = w_z | (w_n != w_v);
            default: w_cond_ex = 1'b1;
        endcase
    end

    assign in_ready = ~r_out_valid | out_ready;
    assign w_accept = in_valid & in_ready;
    assign w_drain  = r_out_valid & out_ready;

    always_comb begin
        w_op_next.result = alu_result;
        w_op_next.wa3    = wa3;
        w_op_next.reg_w  = reg_w & w_cond_ex;
        w_op_next.mem_w  = mem_w & w_cond_ex;
        w_op_next.pcsrc  = pcs & w_cond_ex;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_op         <= '0;
            r_out_valid  <= 1'b0;
            r_flags      <= '0;
            r_fail_count <= '0;
        end else if (w_accept) begin
            r_op        <= w_op_next;
            r_out_valid <= 1'b1;
            if (w_cond_ex) begin
                if (flag_w[1]) r_flags[3:2] <= alu_flags[3:2];
                if (flag_w[0]) r_flags[1:0] <= alu_flags[1:0];
            end else if (r_fail_count != '1) begin
                r_fail_count <= r_fail_count + CNT_W'(1);
            end
        end else if (w_drain) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid  = r_out_valid;
    assign out_result = r_op.result;
    assign out_wa3    = r_op.wa3;
    assign out_reg_w  = r_op.reg_w;
    assign out_mem_w  = r_op.mem_w;
    assign out_pcsrc  = r_op.pcsrc;
    assign flags      = r_flags;
    assign fail_count = r_fail_count;
endmodule

// File: tb/tb_cond_flag_stage.sv
// Bench for cond_flag_stage: vector table, directed stall/saturation/reset
// sequences and a randomized run against a behavioural model.
module tb_cond_flag_stage;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 4;
    localparam int CNT_W  = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic              clk = 1'b0;
    logic              reset;
    logic              in_valid;
    logic              in_ready;
    logic [3:0]        cond;
    logic [3:0]        alu_flags;
    logic [1:0]        flag_w;
    logic [DATA_W-1:0] alu_result;
    logic [ADDR_W-1:0] wa3;
    logic              reg_w, mem_w, pcs;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_result;
    logic [ADDR_W-1:0] out_wa3;
    logic              out_reg_w, out_mem_w, out_pcsrc;
    logic [3:0]        flags;
    logic [CNT_W-1:0]  fail_count;

    cond_flag_stage #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .cond(cond), .alu_flags(alu_flags), .flag_w(flag_w), .alu_result(alu_result),
        .wa3(wa3), .reg_w(reg_w), .mem_w(mem_w), .pcs(pcs), .out_valid(out_valid),
        .out_ready(out_ready), .out_result(out_result), .out_wa3(out_wa3),
        .out_reg_w(out_reg_w), .out_mem_w(out_mem_w), .out_pcsrc(out_pcsrc),
        .flags(flags), .fail_count(fail_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural model state
    bit       m_n, m_z, m_c, m_v;
    bit       m_valid;
    bit [31:0] m_result;
    bit [3:0] m_wa3;
    bit       m_regw, m_memw, m_pcsrc;
    int       m_fail;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ARM-style: odd codes are the negation of the preceding even code.
    function automatic bit passes(input bit [3:0] c);
        bit base;
        case (c[3:1])
            3'd0: base = m_z;
            3'd1: base = m_c;
            3'd2: base = m_n;
            3'd3: base = m_v;
            3'd4: base = m_c && !m_z;
            3'd5: base = (m_n == m_v);
            3'd6: base = !m_z && (m_n == m_v);
            default: return 1'b1;
        endcase
        return c[0] ? !base : base;
    endfunction

    function automatic bit [3:0] m_flags();
        return {m_n, m_z, m_c, m_v};
    endfunction

    task automatic model_reset();
        {m_n, m_z, m_c, m_v} = 4'b0;
        m_valid = 0; m_result = 0; m_wa3 = 0;
        m_regw = 0; m_memw = 0; m_pcsrc = 0; m_fail = 0;
    endtask

    // Called just after a negedge; returns at the following negedge.
    task automatic apply(input bit iv, input bit ordy, input bit [3:0] c, input bit [3:0] af,
                         input bit [1:0] fw, input bit [31:0] res, input bit [3:0] wa,
                         input bit rw, input bit mw, input bit pc);
        bit acc, ce;
        in_valid = iv; out_ready = ordy; cond = c; alu_flags = af; flag_w = fw;
        alu_result = res; wa3 = wa; reg_w = rw; mem_w = mw; pcs = pc;
        #1;
        chk("in_ready", in_ready, !m_valid || ordy);
        acc = iv && (!m_valid || ordy);
        ce  = passes(c);
        @(posedge clk);
        if (acc) begin
            m_valid = 1; m_result = res; m_wa3 = wa;
            m_regw = rw && ce; m_memw = mw && ce; m_pcsrc = pc && ce;
            if (ce) begin
                if (fw[1]) begin m_n = af[3]; m_z = af[2]; end
                if (fw[0]) begin m_c = af[1]; m_v = af[0]; end
            end else if (m_fail < CNT_MAX) begin
                m_fail++;
            end
        end else if (m_valid && ordy) begin
            m_valid = 0;
        end
        @(negedge clk);
    endtask

    task automatic check_all();
        chk("flags", flags, m_flags());
        chk("out_valid", out_valid, m_valid);
        chk("out_result", out_result, m_result);
        chk("out_wa3", out_wa3, m_wa3);
        chk("out_reg_w", out_reg_w, m_regw);
        chk("out_mem_w", out_mem_w, m_memw);
        chk("out_pcsrc", out_pcsrc, m_pcsrc);
        chk("fail_count", fail_count, m_fail);
    endtask

    typedef struct {
        bit [3:0]  c, af;
        bit [1:0]  fw;
        bit [31:0] res;
        bit        rw, mw, pc, iv, ordy;
        bit [3:0]  e_flags;
        bit        e_valid, e_rw, e_mw, e_pc;
        bit [31:0] e_res;
        int        e_fail;
    } vec_t;

    vec_t tbl[17];

    initial begin
        //          c     af    fw  res    rw mw pc iv or  eflg  ev er em ep eres   efail
        tbl[0]  = '{4'hE, 4'h4, 3, 32'h0,    1, 0, 0, 1, 1, 4'h4, 1, 1, 0, 0, 32'h0,    0};
        tbl[1]  = '{4'h0, 4'h0, 0, 32'h1234, 1, 0, 0, 1, 1, 4'h4, 1, 1, 0, 0, 32'h1234, 0};
        tbl[2]  = '{4'h1, 4'hF, 3, 32'h5,    1, 1, 1, 1, 1, 4'h4, 1, 0, 0, 0, 32'h5,    1};
        tbl[3]  = '{4'hE, 4'h9, 3, 32'h6,    0, 1, 0, 1, 1, 4'h9, 1, 0, 1, 0, 32'h6,    1};
        tbl[4]  = '{4'hA, 4'h2, 1, 32'h7,    0, 0, 1, 1, 1, 4'hA, 1, 0, 0, 1, 32'h7,    1};
        tbl[5]  = '{4'hB, 4'h0, 0, 32'h8,    0, 0, 1, 1, 1, 4'hA, 1, 0, 0, 1, 32'h8,    1};
        tbl[6]  = '{4'h8, 4'h4, 2, 32'h9,    1, 0, 0, 1, 1, 4'h6, 1, 1, 0, 0, 32'h9,    1};
        tbl[7]  = '{4'h9, 4'h0, 1, 32'hA,    1, 0, 0, 1, 1, 4'h4, 1, 1, 0, 0, 32'hA,    1};
        tbl[8]  = '{4'hC, 4'hF, 3, 32'hB,    1, 0, 0, 1, 1, 4'h4, 1, 0, 0, 0, 32'hB,    2};
        tbl[9]  = '{4'hD, 4'h3, 3, 32'hC,    1, 0, 0, 1, 1, 4'h3, 1, 1, 0, 0, 32'hC,    2};
        tbl[10] = '{4'h2, 4'hF, 0, 32'hD,    1, 0, 0, 1, 1, 4'h3, 1, 1, 0, 0, 32'hD,    2};
        tbl[11] = '{4'h7, 4'h0, 3, 32'hE,    1, 0, 0, 1, 1, 4'h3, 1, 0, 0, 0, 32'hE,    3};
        tbl[12] = '{4'hF, 4'h0, 3, 32'hF0,   1, 0, 0, 1, 1, 4'h0, 1, 1, 0, 0, 32'hF0,   3};
        tbl[13] = '{4'h5, 4'h0, 0, 32'h99,   1, 0, 0, 0, 1, 4'h0, 0, 1, 0, 0, 32'hF0,   3};
        tbl[14] = '{4'h5, 4'h8, 3, 32'h55,   1, 0, 0, 1, 0, 4'h8, 1, 1, 0, 0, 32'h55,   3};
        tbl[15] = '{4'h4, 4'h0, 3, 32'h77,   1, 1, 1, 1, 0, 4'h8, 1, 1, 0, 0, 32'h55,   3};
        tbl[16] = '{4'h4, 4'h0, 0, 32'h66,   0, 1, 0, 1, 1, 4'h8, 1, 0, 1, 0, 32'h66,   3};

        reset = 0; in_valid = 0; out_ready = 0; cond = 0; alu_flags = 0; flag_w = 0;
        alu_result = 0; wa3 = 0; reg_w = 0; mem_w = 0; pcs = 0;
        model_reset();
        repeat (3) @(negedge clk);
        reset = 1;
        @(negedge clk);
        chk("rst_flags", flags, 4'h0);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_fail_count", fail_count, 0);

        for (int i = 0; i < 17; i++) begin
            apply(tbl[i].iv, tbl[i].ordy, tbl[i].c, tbl[i].af, tbl[i].fw, tbl[i].res,
                  4'(i), tbl[i].rw, tbl[i].mw, tbl[i].pc);
            chk("tbl_flags", flags, tbl[i].e_flags);
            chk("tbl_out_valid", out_valid, tbl[i].e_valid);
            chk("tbl_reg_w", out_reg_w, tbl[i].e_rw);
            chk("tbl_mem_w", out_mem_w, tbl[i].e_mw);
            chk("tbl_pcsrc", out_pcsrc, tbl[i].e_pc);
            chk("tbl_result", out_result, tbl[i].e_res);
            chk("tbl_fail", fail_count, tbl[i].e_fail);
        end

        // Stall: held op must stay put while a new op waits upstream.
        apply(1, 1, 4'hE, 4'h0, 0, 32'hAAAA, 4'h3, 1, 1, 0);
        for (int i = 0; i < 3; i++) begin
            apply(1, 0, 4'hE, 4'hF, 3, 32'hBBBB, 4'h5, 0, 0, 1);
            chk("stall_in_ready", in_ready, 1'b0);
            chk("stall_result", out_result, 32'hAAAA);
            check_all();
        end
        apply(1, 1, 4'hE, 4'hF, 3, 32'hBBBB, 4'h5, 0, 0, 1);
        chk("unstall_result", out_result, 32'hBBBB);
        chk("unstall_flags", flags, 4'hF);
        check_all();

        // Saturation of the fail counter, then reset in the middle of a stall.
        reset = 0; #1; model_reset(); @(negedge clk); reset = 1;
        apply(1, 1, 4'hE, 4'h0, 3, 32'h0, 4'h0, 0, 0, 0);
        for (int i = 1; i <= 20; i++) begin
            apply(1, 1, 4'h0, 4'hF, 3, 32'(i), 4'h1, 1, 1, 1);
            if (i == 15) chk("sat_reach", fail_count, 4'hF);
            if (i == 20) chk("sat_hold", fail_count, 4'hF);
            check_all();
        end
        apply(1, 0, 4'hE, 4'hF, 3, 32'h0, 4'h0, 0, 0, 0);
        #2 reset = 0;
        #1;
        chk("midrst_out_valid", out_valid, 1'b0);
        chk("midrst_flags", flags, 4'h0);
        chk("midrst_fail", fail_count, 0);
        model_reset();
        @(negedge clk);
        reset = 1;

        for (int i = 0; i < 400; i++) begin
            apply($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 7, 4'($urandom),
                  4'($urandom), 2'($urandom), $urandom, 4'($urandom),
                  1'($urandom), 1'($urandom), 1'($urandom));
            check_all();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
